mac_rr_scheduler: RTL and testbench



---
 rtl/mac_rr_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_mac_rr_scheduler.sv | 527 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rr_scheduler.sv
// mac_rr_scheduler
// ----------------
// Shares one Taylor-series mac engine between NUM_REQ requesters.
// Requesters are served in round-robin order. Each grant covers one whole
// burst ending in last. The scheduler then waits for the engine's result
// and returns it tagged with the requester index. It re-arbitrates only
// after the response has been accepted.
//
// Optional feature: define MAC_SCHED_TIMEOUT_EN to add a WAIT-state
// watchdog. The watchdog turns a missing mac_done_i into an error response
// after TIMEOUT_CYCLES cycles. Without the macro, WAIT waits forever and
// rsp_err_o is tied to 0.
//
// Ports
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   req_valid_i       : per-requester sample valid
//   req_data_i        : packed samples, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i        : per-requester end-of-burst flag
//   req_terms_i       : packed term counts, requester k at [k*ADDR_LINES +: ADDR_LINES]
//   req_ready_o       : per-requester ready, only the granted bit can be set
//   mac_signal_o      : sample towards the engine FIFO
//   mac_wr_en_o       : engine FIFO write strobe
//   mac_last_o        : engine last/start strobe
//   mac_terms_o       : term count latched at grant
//   mac_full_i        : engine FIFO full
//   mac_done_i        : engine result valid pulse
//   mac_result_i      : engine result
//   rsp_valid_o       : response valid, held until rsp_ready_i
//   rsp_ready_i       : response accept
//   rsp_id_o          : owner of the response
//   rsp_data_o        : latched engine result
//   rsp_err_o         : watchdog expiry flag
//   busy_o            : scheduler is not idle

module mac_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_LINES     = 5,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*ADDR_LINES-1:0] req_terms_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [DATA_WIDTH-1:0]         mac_signal_o,
    output logic                          mac_wr_en_o,
    output logic                          mac_last_o,
    output logic [ADDR_LINES-1:0]         mac_terms_o,
    input  logic                          mac_full_i,
    input  logic                          mac_done_i,
    input  logic [DATA_WIDTH-1:0]         mac_result_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [ID_W-1:0]               rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gnt;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   ptr_next;
    logic              any_valid;
    logic              accept;
    logic              burst_end;
    logic [ADDR_LINES-1:0] win_terms;

    // Cyclic priority search. The first valid requester at or above ptr
    // wins, and the search wraps around to index 0.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_valid && req_valid_i[(int'(ptr) + i) % NUM_REQ]) begin
                winner    = ID_W'((int'(ptr) + i) % NUM_REQ);
                any_valid = 1'b1;
            end
        end
    end

    assign win_terms = req_terms_i[int'(winner)*ADDR_LINES +: ADDR_LINES];
    assign ptr_next  = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

    assign accept    = (state == S_STREAM) & req_valid_i[gnt] & ~mac_full_i;
    assign burst_end = accept & req_last_i[gnt];

    // Stream path is combinational so the burst moves at one beat per cycle.
    // Everything reads 0 outside STREAM so that reset and idle look identical.
    always_comb begin
        req_ready_o  = '0;
        mac_signal_o = '0;
        mac_wr_en_o  = 1'b0;
        mac_last_o   = 1'b0;
        if (state == S_STREAM) begin
            req_ready_o[gnt] = ~mac_full_i;
            mac_signal_o     = req_data_i[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
            mac_wr_en_o      = accept;
            mac_last_o       = burst_end;
        end
    end

    assign rsp_valid_o = (state == S_RESP);
    assign rsp_id_o    = (state == S_RESP) ? gnt : '0;
    assign busy_o      = (state != S_IDLE);

`ifdef MAC_SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        wd_expire;

    // The counter holds the number of WAIT cycles already completed.
    // Expiry fires when this cycle's increment would bring it to
    // TIMEOUT_CYCLES, so RESP starts exactly TIMEOUT_CYCLES after WAIT entry.
    assign wd_expire = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            mac_terms_o <= '0;
            rsp_data_o  <= '0;
`ifdef MAC_SCHED_TIMEOUT_EN
            wd_cnt      <= '0;
            rsp_err_o   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        gnt         <= winner;
                        mac_terms_o <= win_terms;
                        state       <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (burst_end) begin
                        state  <= S_WAIT;
`ifdef MAC_SCHED_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // A result arriving on the expiry cycle takes priority
                    // over the watchdog.
                    if (mac_done_i) begin
                        rsp_data_o <= mac_result_i;
`ifdef MAC_SCHED_TIMEOUT_EN
                        rsp_err_o  <= 1'b0;
`endif
                        state      <= S_RESP;
                    end
`ifdef MAC_SCHED_TIMEOUT_EN
                    else if (wd_expire) begin
                        rsp_data_o <= '0;
                        rsp_err_o  <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        ptr   <= ptr_next;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb_mac_rr_scheduler
// -------------------
// Self-checking bench for mac_rr_scheduler (NUM_REQ=4, TIMEOUT_CYCLES=20).
// A transaction-level model of the scheduler is stepped on every falling
// edge and compared against all DUT outputs. Directed scenarios add literal
// expectations on the logged write and response streams.

module tb_mac_rr_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int AL      = 5;
    localparam int TO      = 20;
    localparam int DEPTH   = 32;

    localparam int P_IDLE   = 0;
    localparam int P_STREAM = 1;
    localparam int P_WAIT   = 2;
    localparam int P_RESP   = 3;

    logic                  clk_i;
    logic                  rst_i;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ*DW-1:0] req_data_i;
    logic [NUM_REQ-1:0]    req_last_i;
    logic [NUM_REQ*AL-1:0] req_terms_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [DW-1:0]         mac_signal_o;
    logic                  mac_wr_en_o;
    logic                  mac_last_o;
    logic [AL-1:0]         mac_terms_o;
    logic                  mac_full_i;
    logic                  mac_done_i;
    logic [DW-1:0]         mac_result_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [1:0]            rsp_id_o;
    logic [DW-1:0]         rsp_data_o;
    logic                  rsp_err_o;
    logic                  busy_o;

    mac_rr_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .DATA_WIDTH     (DW),
        .ADDR_LINES     (AL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_last_i   (req_last_i),
        .req_terms_i  (req_terms_i),
        .req_ready_o  (req_ready_o),
        .mac_signal_o (mac_signal_o),
        .mac_wr_en_o  (mac_wr_en_o),
        .mac_last_o   (mac_last_o),
        .mac_terms_o  (mac_terms_o),
        .mac_full_i   (mac_full_i),
        .mac_done_i   (mac_done_i),
        .mac_result_i (mac_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Per-requester beat FIFOs feeding the request ports.
    logic [DW-1:0] src_data  [NUM_REQ][DEPTH];
    logic          src_last  [NUM_REQ][DEPTH];
    int            src_head  [NUM_REQ];
    int            src_tail  [NUM_REQ];
    logic [AL-1:0] src_terms [NUM_REQ];

    // Observed DUT traffic for the directed literal checks.
    logic [DW-1:0] wr_data_q [$];
    logic          wr_last_q [$];
    int            wr_cyc_q  [$];
    logic [1:0]    rsp_id_q  [$];
    logic [DW-1:0] rsp_data_q[$];
    logic          rsp_err_q [$];

    // Model state.
    int            m_phase;
    int            m_owner;
    int            m_ptr;
    int            m_wait;
    int            m_idx;
    logic          m_found;
    logic [AL-1:0] m_terms;
    logic [DW-1:0] m_data;
    logic          m_err;

    logic [NUM_REQ-1:0] e_ready;
    logic               e_wr;
    logic               e_last;
    logic [DW-1:0]      e_sig;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic report_expired(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait bound expired (got no event, expected one) cycle %0d",
                 name, cyc);
    endtask

    task automatic apply_stimulus(input int k, input logic [DW-1:0] d, input logic l);
        src_data[k][src_tail[k] % DEPTH] = d;
        src_last[k][src_tail[k] % DEPTH] = l;
        src_tail[k]++;
    endtask

    task automatic clear_sources();
        for (int k = 0; k < NUM_REQ; k++) begin
            src_head[k] = 0;
            src_tail[k] = 0;
        end
    endtask

    task automatic clear_logs();
        wr_data_q.delete();
        wr_last_q.delete();
        wr_cyc_q.delete();
        rsp_id_q.delete();
        rsp_data_q.delete();
        rsp_err_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_phase(input int ph, input string name);
        int b;
        b = 0;
        while (m_phase != ph && b < 200) begin
            tick(1);
            b++;
        end
        if (m_phase != ph) report_expired(name);
    endtask

    task automatic wait_rsp(input string name);
        int b;
        b = 0;
        while (rsp_valid_o !== 1'b1 && b < 200) begin
            tick(1);
            b++;
        end
        if (rsp_valid_o !== 1'b1) report_expired(name);
    endtask

    task automatic wait_wr(input int n, input string name);
        int b;
        b = 0;
        while (wr_data_q.size() < n && b < 200) begin
            tick(1);
            b++;
        end
        if (wr_data_q.size() < n) report_expired(name);
    endtask

    task automatic engine_done(input logic [DW-1:0] result, input string name);
        wait_phase(P_WAIT, name);
        mac_result_i = result;
        mac_done_i   = 1'b1;
        tick(1);
        mac_done_i   = 1'b0;
        mac_result_i = '0;
    endtask

    task automatic handshake(input string name);
        wait_rsp(name);
        rsp_ready_i = 1'b1;
        tick(1);
        rsp_ready_i = 1'b0;
    endtask

    // Requester driver: a beat leaves its FIFO after a valid&ready edge.
    initial begin
        logic [NUM_REQ-1:0] hs;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        req_terms_i = '0;
        forever begin
            @(negedge clk_i);
            hs = req_valid_i & req_ready_o;
            @(posedge clk_i);
            #2;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (hs[k] && !rst_i && src_head[k] != src_tail[k]) src_head[k]++;
                req_valid_i[k] = (src_head[k] != src_tail[k]);
                req_data_i[k*DW +: DW] = req_valid_i[k] ? src_data[k][src_head[k] % DEPTH] : '0;
                req_last_i[k] = req_valid_i[k] ? src_last[k][src_head[k] % DEPTH] : 1'b0;
                req_terms_i[k*AL +: AL] = src_terms[k];
            end
        end
    end

    // Transaction-level scheduler model and per-cycle compare.
    initial begin
        m_phase = P_IDLE;
        m_owner = 0;
        m_ptr   = 0;
        m_wait  = 0;
        m_terms = '0;
        m_data  = '0;
        m_err   = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                m_phase = P_IDLE;
                m_owner = 0;
                m_ptr   = 0;
                m_wait  = 0;
                m_terms = '0;
                m_data  = '0;
                m_err   = 1'b0;
            end

            e_ready = '0;
            e_wr    = 1'b0;
            e_last  = 1'b0;
            e_sig   = '0;
            if (m_phase == P_STREAM) begin
                e_ready[m_owner] = ~mac_full_i;
                e_wr   = req_valid_i[m_owner] & ~mac_full_i;
                e_last = e_wr & req_last_i[m_owner];
                e_sig  = req_data_i[m_owner*DW +: DW];
            end

            check_output("busy_o",       busy_o,       m_phase != P_IDLE);
            check_output("req_ready_o",  req_ready_o,  e_ready);
            check_output("mac_wr_en_o",  mac_wr_en_o,  e_wr);
            check_output("mac_last_o",   mac_last_o,   e_last);
            check_output("mac_signal_o", mac_signal_o, e_sig);
            check_output("mac_terms_o",  mac_terms_o,  m_terms);
            check_output("rsp_valid_o",  rsp_valid_o,  m_phase == P_RESP);
            check_output("rsp_id_o",     rsp_id_o,     (m_phase == P_RESP) ? m_owner : 0);
            check_output("rsp_data_o",   rsp_data_o,   m_data);
            check_output("rsp_err_o",    rsp_err_o,    m_err);

            if (!rst_i) begin
                if (mac_wr_en_o === 1'b1) begin
                    wr_data_q.push_back(mac_signal_o);
                    wr_last_q.push_back(mac_last_o);
                    wr_cyc_q.push_back(cyc);
                end
                if (rsp_valid_o === 1'b1 && rsp_ready_i) begin
                    rsp_id_q.push_back(rsp_id_o);
                    rsp_data_q.push_back(rsp_data_o);
                    rsp_err_q.push_back(rsp_err_o);
                end

                case (m_phase)
                    P_IDLE: begin
                        m_found = 1'b0;
                        for (int i = 0; i < NUM_REQ; i++) begin
                            m_idx = (m_ptr + i) % NUM_REQ;
                            if (!m_found && req_valid_i[m_idx]) begin
                                m_found = 1'b1;
                                m_owner = m_idx;
                            end
                        end
                        if (m_found) begin
                            m_terms = req_terms_i[m_owner*AL +: AL];
                            m_phase = P_STREAM;
                        end
                    end
                    P_STREAM: begin
                        if (e_last) begin
                            m_phase = P_WAIT;
                            m_wait  = 0;
                        end
                    end
                    P_WAIT: begin
                        m_wait++;
                        if (mac_done_i) begin
                            m_data  = mac_result_i;
                            m_err   = 1'b0;
                            m_phase = P_RESP;
                        end
`ifdef MAC_SCHED_TIMEOUT_EN
                        else if (m_wait == TO) begin
                            m_data  = '0;
                            m_err   = 1'b1;
                            m_phase = P_RESP;
                        end
`endif
                    end
                    default: begin
                        if (rsp_ready_i) begin
                            m_ptr   = (m_owner + 1) % NUM_REQ;
                            m_phase = P_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        rst_i        = 1'b1;
        mac_full_i   = 1'b0;
        mac_done_i   = 1'b0;
        mac_result_i = '0;
        rsp_ready_i  = 1'b0;
        clear_sources();
        for (int k = 0; k < NUM_REQ; k++) src_terms[k] = '0;

        // Reset values.
        @(negedge clk_i);
        check_output("reset_busy",      busy_o,      0);
        check_output("reset_rsp_valid", rsp_valid_o, 0);
        check_output("reset_wr_en",     mac_wr_en_o, 0);
        check_output("reset_ready",     req_ready_o, 0);
        check_output("reset_rsp_data",  rsp_data_o,  0);
        tick(1);
        rst_i = 1'b0;
        tick(2);

        // Single burst from requester 2.
        $display("[TB] single burst");
        clear_logs();
        src_terms[2] = 5'd4;
        apply_stimulus(2, 32'h10, 1'b0);
        apply_stimulus(2, 32'h20, 1'b0);
        apply_stimulus(2, 32'h30, 1'b1);
        engine_done(32'hABCD, "t1_wait");
        wait_rsp("t1_rsp");
        check_output("t1_rsp_id",   rsp_id_o,    2);
        check_output("t1_rsp_data", rsp_data_o,  32'hABCD);
        check_output("t1_terms",    mac_terms_o, 4);
        handshake("t1_hs");
        check_output("t1_wr_count", wr_data_q.size(), 3);
        if (wr_data_q.size() == 3) begin
            check_output("t1_wr0", {wr_last_q[0], wr_data_q[0]}, {1'b0, 32'h10});
            check_output("t1_wr1", {wr_last_q[1], wr_data_q[1]}, {1'b0, 32'h20});
            check_output("t1_wr2", {wr_last_q[2], wr_data_q[2]}, {1'b1, 32'h30});
            check_output("t1_consec01", wr_cyc_q[1] - wr_cyc_q[0], 1);
            check_output("t1_consec12", wr_cyc_q[2] - wr_cyc_q[1], 1);
        end

        // Round-robin fairness between requesters 0, 1 and 3.
        $display("[TB] round-robin fairness");
        rst_i = 1'b1;
        clear_sources();
        tick(2);
        rst_i = 1'b0;
        clear_logs();
        for (int k = 0; k < NUM_REQ; k++) src_terms[k] = AL'(k + 1);
        apply_stimulus(0, 32'h100, 1'b1);
        apply_stimulus(1, 32'h101, 1'b1);
        apply_stimulus(3, 32'h103, 1'b1);
        apply_stimulus(0, 32'h200, 1'b1);
        apply_stimulus(1, 32'h201, 1'b1);
        apply_stimulus(3, 32'h203, 1'b1);
        rsp_ready_i = 1'b1;
        for (int n = 0; n < 6; n++) engine_done(DW'(32'h1000 + n), "t2_wait");
        tick(4);
        rsp_ready_i = 1'b0;
        check_output("t2_rsp_count", rsp_id_q.size(), 6);
        if (rsp_id_q.size() == 6) begin
            check_output("t2_order",
                         {rsp_id_q[0], rsp_id_q[1], rsp_id_q[2], rsp_id_q[3], rsp_id_q[4], rsp_id_q[5]},
                         {2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3});
            check_output("t2_data0", rsp_data_q[0], 32'h1000);
            check_output("t2_data5", rsp_data_q[5], 32'h1005);
        end
        if (wr_data_q.size() == 6) begin
            check_output("t2_wr2", wr_data_q[2], 32'h103);
            check_output("t2_wr3", wr_data_q[3], 32'h200);
        end else begin
            check_output("t2_wr_count", wr_data_q.size(), 6);
        end

        // Backpressure in the middle of a 4-sample burst.
        $display("[TB] backpressure");
        clear_logs();
        src_terms[1] = 5'd7;
        apply_stimulus(1, 32'hA1, 1'b0);
        apply_stimulus(1, 32'hA2, 1'b0);
        apply_stimulus(1, 32'hA3, 1'b0);
        apply_stimulus(1, 32'hA4, 1'b1);
        wait_wr(2, "t3_wr2");
        mac_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_output("t3_full_wr",    mac_wr_en_o, 0);
            check_output("t3_full_ready", req_ready_o, 0);
            check_output("t3_full_terms", mac_terms_o, 7);
            tick(1);
        end
        check_output("t3_stalled_count", wr_data_q.size(), 2);
        mac_full_i = 1'b0;
        engine_done(32'h5555, "t3_wait");
        handshake("t3_hs");
        check_output("t3_wr_count", wr_data_q.size(), 4);
        if (wr_data_q.size() == 4) begin
            check_output("t3_order", {wr_data_q[0], wr_data_q[1], wr_data_q[2], wr_data_q[3]},
                         {32'hA1, 32'hA2, 32'hA3, 32'hA4});
            check_output("t3_lasts", {wr_last_q[0], wr_last_q[1], wr_last_q[2], wr_last_q[3]},
                         4'b0001);
        end

        // Response stall with stray done pulses and a competing requester.
        $display("[TB] response stall");
        clear_logs();
        src_terms[2] = 5'd3;
        src_terms[0] = 5'd9;
        apply_stimulus(2, 32'h77, 1'b1);
        apply_stimulus(0, 32'h66, 1'b1);
        engine_done(32'h1234, "t4_wait");
        wait_rsp("t4_rsp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check_output("t4_hold_valid", rsp_valid_o, 1);
            check_output("t4_hold_id",    rsp_id_o,    2);
            check_output("t4_hold_data",  rsp_data_o,  32'h1234);
            check_output("t4_no_grant",   req_ready_o, 0);
            tick(1);
            mac_done_i   = (i % 2 == 0);
            mac_result_i = 32'hDEAD;
        end
        mac_done_i   = 1'b0;
        mac_result_i = '0;
        handshake("t4_hs1");
        engine_done(32'h4321, "t4_wait2");
        handshake("t4_hs2");
        check_output("t4_rsp_count", rsp_id_q.size(), 2);
        if (rsp_id_q.size() == 2) begin
            check_output("t4_rsp0", {rsp_id_q[0], rsp_data_q[0]}, {2'd2, 32'h1234});
            check_output("t4_rsp1", {rsp_id_q[1], rsp_data_q[1]}, {2'd0, 32'h4321});
        end

        // Reset while waiting for the engine.
        $display("[TB] reset in WAIT");
        src_terms[3] = 5'd2;
        apply_stimulus(3, 32'h33, 1'b1);
        wait_phase(P_WAIT, "t5_wait");
        rst_i = 1'b1;
        @(negedge clk_i);
        check_output("t5_busy",      busy_o,       0);
        check_output("t5_rsp_valid", rsp_valid_o,  0);
        check_output("t5_terms",     mac_terms_o,  0);
        check_output("t5_rsp_data",  rsp_data_o,   0);
        check_output("t5_wr_en",     mac_wr_en_o,  0);
        check_output("t5_last",      mac_last_o,   0);
        check_output("t5_signal",    mac_signal_o, 0);
        clear_sources();
        clear_logs();
        src_terms[0] = 5'd5;
        apply_stimulus(3, 32'hC3, 1'b1);
        apply_stimulus(0, 32'hC0, 1'b1);
        tick(1);
        rst_i = 1'b0;
        engine_done(32'hBEEF, "t5_wait1");
        handshake("t5_hs1");
        engine_done(32'hFACE, "t5_wait2");
        handshake("t5_hs2");
        check_output("t5_rsp_count", rsp_id_q.size(), 2);
        if (rsp_id_q.size() == 2) begin
            check_output("t5_rsp0", {rsp_id_q[0], rsp_data_q[0]}, {2'd0, 32'hBEEF});
            check_output("t5_rsp1", {rsp_id_q[1], rsp_data_q[1]}, {2'd3, 32'hFACE});
        end

        // Engine never answers.
        $display("[TB] watchdog");
        clear_logs();
        src_terms[1] = 5'd6;
        apply_stimulus(1, 32'h99, 1'b1);
        wait_phase(P_WAIT, "t6_wait");
`ifdef MAC_SCHED_TIMEOUT_EN
        tick(TO - 1);
        check_output("t6_before_expiry", rsp_valid_o, 0);
        tick(1);
        check_output("t6_valid", rsp_valid_o, 1);
        check_output("t6_err",   rsp_err_o,   1);
        check_output("t6_data",  rsp_data_o,  0);
        check_output("t6_id",    rsp_id_o,    1);
        handshake("t6_hs");
`else
        tick(100);
        check_output("t6_still_busy", busy_o,      1);
        check_output("t6_no_rsp",     rsp_valid_o, 0);
        check_output("t6_no_err",     rsp_err_o,   0);
        engine_done(32'h600D, "t6_done");
        handshake("t6_hs");
        if (rsp_data_q.size() == 1) check_output("t6_late_data", rsp_data_q[0], 32'h600D);
        else check_output("t6_rsp_count", rsp_data_q.size(), 1);
`endif

        tick(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
